// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Never8 instruction fetch sequencer with 2-entry prefetch queue (optional FETCH_BYPASS_EN)
module fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc
);

   logic [ADDR_W-1:0] fetch_pc;
   logic              inflight_valid;
   logic [ADDR_W-1:0] inflight_pc;
   logic [DATA_W-1:0] fifo_data [2];
   logic [ADDR_W-1:0] fifo_pc   [2];
   logic [1:0]        count;
   logic              rd_ptr;

   logic              pop;
   logic              fifo_pop;
   logic              push;
   logic              issue;
   logic              bypass;
   logic              wr_ptr;
   logic [2:0]        occupancy;

   // Handshake, issue decision and output muxing; the in-flight fetch reserves a queue slot
   always_comb begin
      bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
      // An empty queue lets a live return go straight to the decoder
      bypass = (count == 2'd0) && inflight_valid && !jump_valid;
`endif
      instr_valid = (count != 2'd0) || bypass;
      instr_data  = bypass ? mem_data    : fifo_data[rd_ptr];
      instr_pc    = bypass ? inflight_pc : fifo_pc[rd_ptr];
      pop         = instr_valid && instr_ready;
      fifo_pop    = pop && (count != 2'd0);
      occupancy   = {1'b0, count} + {2'b0, inflight_valid} - {2'b0, pop};
      issue       = !jump_valid && (occupancy < 3'd2);
      // A return is dropped on a jump, and a bypassed byte that was taken needs no slot
      push        = inflight_valid && !jump_valid && !(bypass && pop);
      wr_ptr      = rd_ptr ^ count[0];
      mem_addr    = fetch_pc;
   end

   // Program counter, in-flight tracking and queue storage; a jump flushes everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc       <= RESET_PC;
         inflight_valid <= 1'b0;
         inflight_pc    <= '0;
         count          <= 2'd0;
         rd_ptr         <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else if (jump_valid) begin
         fetch_pc       <= jump_addr;
         inflight_valid <= 1'b0;
         count          <= 2'd0;
      end else begin
         inflight_valid <= issue;
         if (issue) begin
            fetch_pc    <= fetch_pc + 1'b1;
            inflight_pc <= fetch_pc;
         end
         if (push) begin
            fifo_data[wr_ptr] <= mem_data;
            fifo_pc[wr_ptr]   <= inflight_pc;
         end
         rd_ptr <= rd_ptr ^ fifo_pop;
         count  <= count + {1'b0, push} - {1'b0, fifo_pop};
      end
   end

`ifndef SYNTHESIS
   // The issue rule should make queue overflow impossible
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !fifo_pop && !jump_valid && count == 2'd2));
   a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (honours FETCH_BYPASS_EN)
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] mem_addr;
   logic [7:0] mem_data = 8'h00;
   logic       jump_valid = 1'b0;
   logic [7:0] jump_addr = 8'h00;
   logic       instr_valid;
   logic       instr_ready = 1'b0;
   logic [7:0] instr_data;
   logic [7:0] instr_pc;

   int         nvec = 0;
   int         nerr = 0;
   int         cyc = 0;
   int         first_v = -1;
   int         first_pop = 0;
   int         last_pop = 0;
   int         npop = 0;
   int         j = 0;
   logic [7:0] exp_q[$];

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
      .jump_valid(jump_valid), .jump_addr(jump_addr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   // program_mem model: mem[a] = a + 1, one-cycle read latency
   always @(posedge clk) mem_data <= mem_addr + 8'd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 8'(i));
   endtask

   // One clock: sample the handshake at the falling edge, then move to just past the rising edge
   task automatic step();
      logic [7:0] e;
      @(negedge clk);
      if (instr_valid && first_v < 0) first_v = cyc;
      if (instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_pop_queue_size", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("pc", {24'b0, instr_pc}, {24'b0, e});
            check("data", {24'b0, instr_data}, {24'b0, e + 8'd1});
            if (npop == 0) first_pop = cyc;
            last_pop = cyc;
            npop++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_until_empty(input int maxc);
      int n = 0;
      instr_ready = 1'b1;
      while (exp_q.size() != 0 && n < maxc) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         check("timeout_remaining", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      instr_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_data", {24'b0, instr_data}, 32'd0);
      check("rst_pc", {24'b0, instr_pc}, 32'd0);
      check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      first_v = -1;
      npop = 0;
   endtask

   initial begin
      @(posedge clk);
      #1;

      // Reset then stream
      do_reset();
      push_exp(8'h00, 4);
      run_until_empty(20);
      check("reset_first_valid_cycle", 32'(first_v), 32'(LAT));
      check("reset_stream_gap", 32'(last_pop - first_pop), 32'd3);

      // Backpressure from cycle 0
      do_reset();
      repeat (10) step();
      check("bp_mem_addr", {24'b0, mem_addr}, 32'h02);
      check("bp_valid", {31'b0, instr_valid}, 32'd1);
      check("bp_data", {24'b0, instr_data}, 32'h01);
      check("bp_pc", {24'b0, instr_pc}, 32'h00);
      npop = 0;
      push_exp(8'h00, 4);
      run_until_empty(20);
      check("bp_release_gap", 32'(last_pop - first_pop), 32'd3);

      // Jump while the queue is full
      repeat (4) step();
      jump_valid = 1'b1;
      jump_addr = 8'h40;
      j = cyc;
      step();
      jump_valid = 1'b0;
      first_v = -1;
      push_exp(8'h40, 3);
      run_until_empty(20);
      check("jump_first_valid_cycle", 32'(first_v), 32'(j + 1 + LAT));

      // Jump with a simultaneous pop and return
      repeat (4) step();
      push_exp(8'h43, 5);
      instr_ready = 1'b1;
      for (int n = 0; n < 20 && exp_q.size() > 1; n++) step();
      jump_valid = 1'b1;
      jump_addr = 8'h80;
      j = cyc;
      step();
      jump_valid = 1'b0;
      check("jump_pop_consumed", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      first_v = -1;
      push_exp(8'h80, 3);
      run_until_empty(20);
      check("jump_pop_first_valid_cycle", 32'(first_v), 32'(j + 1 + LAT));

      // Wrap-around, jumping while the decoder is ready
      push_exp(8'h83, 1);
      instr_ready = 1'b1;
      jump_valid = 1'b1;
      jump_addr = 8'hFE;
      step();
      jump_valid = 1'b0;
      check("wrap_jump_pop_consumed", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      push_exp(8'hFE, 4);
      run_until_empty(20);

      // Reset mid-operation with the queue full
      repeat (4) step();
      check("mid_full_valid", {31'b0, instr_valid}, 32'd1);
      do_reset();
      push_exp(8'h00, 4);
      run_until_empty(20);
      check("rerun_first_valid_cycle", 32'(first_v), 32'(LAT));
      check("rerun_stream_gap", 32'(last_pop - first_pop), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
